flit_tx: RTL and testbench
==========================

Name: flit_tx

Overview:
- Credit-based flit transmitter at each router output port.
- Drives flits into the downstream router's input buffer and tracks free slots there with a credit counter.
- Enforces wormhole packet framing: a head flit opens a packet and a tail flit closes it.
- Sits between the crossbar output and the inter-router link. It is the writer side of the downstream input buffer.

Parameters:
- DATA_WIDTH, 8, flit width. Bits [DATA_WIDTH-1:DATA_WIDTH-2] carry the flit type.
- RAM_DEPTH, 4, downstream buffer RAM depth. Usable downstream slots = RAM_DEPTH-1, which is also the initial credit count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  crossbar presents a flit.
- in_flit  input  DATA_WIDTH  flit from crossbar.
- in_ready  output  1  transmitter accepts in_flit this cycle.
- credit_in  input  1  one-cycle pulse from downstream: one slot freed (downstream read).
- out_valid  output  1  out_flit valid; acts as the downstream buffer wr_en.
- out_flit  output  DATA_WIDTH  registered flit to link.
- credits  output  $clog2(RAM_DEPTH)+1  current credit count.
- busy  output  1  packet in progress (state ACTIVE).
- proto_err  output  1  sticky protocol/credit error flag.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state updates on posedge clk.
- Reset values:
  - out_valid=0, out_flit=0, credits=RAM_DEPTH-1, state=IDLE, busy=0, proto_err=0.
  - Reset mid-packet discards the packet in progress: state returns to IDLE and credits reload to RAM_DEPTH-1.
- Flit types (top 2 bits): 01 HEAD, 00 BODY, 10 TAIL, 11 HEADTAIL (single-flit packet).
- Handshake:
  - in_ready = (credits != 0), combinational. in_ready is 0 while rst is high.
  - A transfer occurs when in_valid && in_ready.
- Forwarding:
  - A legal transfer sets out_flit <= in_flit and out_valid <= 1 on the next edge (latency 1 cycle).
  - Otherwise out_valid <= 0, and out_flit holds its last value.
  - out_valid is high for exactly one cycle per forwarded flit; back-to-back flits give consecutive out_valid cycles.
- Credit counter:
  - Forwarded flit: credits - 1.
  - credit_in: credits + 1.
  - Both in the same cycle: credits unchanged.
  - credit_in while credits==RAM_DEPTH-1 and no forward in that cycle is an overflow: credits stays at max and proto_err <= 1.
  - credits never underflows, because a forward requires in_ready.
- FSM (wormhole lock):
  - IDLE:
    - HEAD forwarded -> ACTIVE.
    - HEADTAIL forwarded -> stay IDLE.
    - BODY or TAIL: accepted (consumed), NOT forwarded, no credit consumed, proto_err <= 1, stay IDLE.
  - ACTIVE:
    - BODY forwarded -> stay ACTIVE.
    - TAIL forwarded -> IDLE.
    - HEAD or HEADTAIL: consumed, dropped, no credit consumed, proto_err <= 1, stay ACTIVE.
  - busy = (state==ACTIVE).
- Dropped flits still require in_ready=1; with credits==0 nothing is consumed.
- proto_err clears only on rst.

Test Plan:
- Reset, then send HEAD 0x45, BODY 0x0A, TAIL 0x8B on consecutive cycles with no credit_in -> out_valid high for 3 consecutive cycles, starting 1 cycle after each accept, with out_flit 0x45, 0x0A, 0x8B. credits goes 3->2->1->0. busy is 1 after the head and 0 after the tail.
- With credits=0 and in_valid held with BODY 0x05 -> in_ready=0 and no out_valid. Pulse credit_in once -> credits=1, in_ready=1, the flit is forwarded the next cycle, and credits returns to 0.
- Simultaneous forward and credit_in at credits=2 -> credits stays 2 and the flit is still forwarded.
- In IDLE send BODY 0x07 -> in_ready=1, no out_valid, credits unchanged at 3, proto_err=1. Then send HEADTAIL 0xC1 -> forwarded, state stays IDLE, credits=2.
- At credits=3, pulse credit_in with no forward -> credits stays 3 and proto_err=1.
- Mid-packet (after HEAD, credits=2) assert rst for 1 cycle -> credits=3, busy=0, out_valid=0, proto_err=0. A following BODY flags proto_err.

Source files
------------

// File: rtl/flit_tx.sv
// flit_tx: credit-based wormhole flit transmitter for one router output port.
// Forwards legally framed flits to the downstream input buffer one cycle after
// acceptance, tracks free downstream slots with a credit counter, and raises a
// sticky error on framing violations or credit overflow.
module flit_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 4,
  localparam int CW        = $clog2(RAM_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_flit,
  output logic                  in_ready,
  input  logic                  credit_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic [CW-1:0]         credits,
  output logic                  busy,
  output logic                  proto_err
);

  // One slot of the downstream RAM is never usable, so max credit is depth-1.
  localparam logic [CW-1:0] CRED_MAX = CW'(RAM_DEPTH - 1);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_HT   = 2'b11;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_flit_q, out_flit_d;
  logic [CW-1:0]         credits_q, credits_d;
  logic                  proto_err_q, proto_err_d;

  logic [1:0] flit_type;
  logic       xfer;
  logic       fwd;
  logic       drop;
  logic       ovf;

  // Outside a packet only packet openers are legal; inside, only continuations.
  function automatic logic legal_flit(input state_t st, input logic [1:0] ft);
    logic ok;
    if (st == IDLE) ok = (ft == T_HEAD) || (ft == T_HT);
    else            ok = (ft == T_BODY) || (ft == T_TAIL);
    return ok;
  endfunction

  // Saturating credit update: a return at full credit is held at the maximum.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic          take,
                                                input logic          give);
    logic [CW-1:0] nxt;
    nxt = cur;
    case ({take, give})
      2'b10:   nxt = cur - CW'(1);
      2'b01:   nxt = (cur == CRED_MAX) ? cur : cur + CW'(1);
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Handshake and transfer classification.
  always_comb begin
    flit_type = in_flit[DATA_WIDTH-1 -: 2];
    in_ready  = !rst && (credits_q != '0);
    xfer      = in_valid && in_ready;
    fwd       = xfer && legal_flit(state_q, flit_type);
    drop      = xfer && !fwd;
    ovf       = credit_in && !fwd && (credits_q == CRED_MAX);
  end

  // Wormhole lock: next state from the type of the forwarded flit.
  always_comb begin
    state_d = state_q;
    if (fwd) begin
      case (flit_type)
        T_HEAD:  state_d = ACTIVE;
        T_TAIL:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q == ACTIVE);
  end

  // Link register, credit counter and sticky error next values.
  always_comb begin
    out_valid_d = fwd;
    out_flit_d  = fwd ? in_flit : out_flit_q;
    credits_d   = credit_next(credits_q, fwd, credit_in);
    proto_err_d = proto_err_q || drop || ovf;
  end

  // State register with synchronous reset; reset discards any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_flit_q  <= '0;
      credits_q   <= CRED_MAX;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      credits_q   <= credits_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign credits   = credits_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_flit_tx.sv
// Testbench for flit_tx: directed scenarios plus randomized traffic, checked
// against a packet-level reference model with a scoreboard of expected flits.
module tb_flit_tx;

  localparam int DW   = 8;
  localparam int RD   = 4;
  localparam int CW   = $clog2(RD) + 1;
  localparam int CMAX = RD - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_flit = '0;
  logic          credit_in = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_flit;
  logic [CW-1:0] credits;
  logic          busy;
  logic          proto_err;

  flit_tx #(.DATA_WIDTH(DW), .RAM_DEPTH(RD)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .credit_in (credit_in),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .credits   (credits),
    .busy      (busy),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] flit;
    int            cyc;
  } exp_t;
  exp_t q[$];

  // Reference model: free downstream slots, packet-open flag, sticky error,
  // last flit put on the link.
  int            m_cr   = CMAX;
  bit            m_pkt  = 1'b0;
  bit            m_err  = 1'b0;
  logic [DW-1:0] m_last = '0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus: drive, predict, then check registered state.
  task automatic step(input bit r, input bit v, input logic [DW-1:0] f, input bit c);
    bit rdy, fwd, starts, ends;
    @(negedge clk);
    rst = r; in_valid = v; in_flit = f; credit_in = c;
    #1;
    rdy = !r && (m_cr > 0);
    chk("in_ready", int'(in_ready), int'(rdy));
    starts = f[DW-2];
    ends   = f[DW-1];
    // A flit is legal when it opens a packet exactly when none is open.
    fwd = v && rdy && (starts != m_pkt);
    if (fwd) q.push_back('{flit: f, cyc: cyc + 1});
    @(posedge clk);
    #1;
    if (r) begin
      m_cr = CMAX; m_pkt = 1'b0; m_err = 1'b0; m_last = '0;
    end else begin
      if (v && rdy && !fwd) m_err = 1'b1;
      if (fwd) begin
        m_cr   = m_cr - 1;
        m_pkt  = (m_pkt || starts) && !ends;
        m_last = f;
      end
      if (c) begin
        m_cr = m_cr + 1;
        if (m_cr > CMAX) begin
          m_cr  = CMAX;
          m_err = 1'b1;
        end
      end
    end
    chk("credits", int'(credits), m_cr);
    chk("busy", int'(busy), int'(m_pkt));
    chk("proto_err", int'(proto_err), int'(m_err));
    chk("out_flit_hold", int'(out_flit), int'(m_last));
  endtask

  // Monitor: every out_valid cycle must match the next expected flit and cycle.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL out_unexpected: out_valid=1 flit=0x%02h expected no output (cycle %0d)",
                 out_flit, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_flit", int'(out_flit), int'(e.flit));
        chk("out_cycle", cyc, e.cyc);
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      chk("out_valid", int'(out_valid), 1);
      void'(q.pop_front());
    end
  end

  initial begin
    // Reset state.
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);

    // HEAD, BODY, TAIL back to back: credits 3->2->1->0.
    step(0, 1, 8'h45, 0);
    step(0, 1, 8'h0A, 0);
    step(0, 1, 8'h8B, 0);
    step(0, 0, 8'h00, 0);

    // Out of credits mid-packet, BODY held until one credit returns.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h41, 0);
    step(0, 1, 8'h02, 0);
    step(0, 1, 8'h03, 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h05, 0);
    step(0, 1, 8'h05, 1);
    step(0, 1, 8'h05, 0);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h8C, 1);
    step(0, 1, 8'h8C, 0);

    // Simultaneous forward and credit return at credits=2.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h46, 0);
    step(0, 1, 8'h0B, 1);
    step(0, 1, 8'h8D, 0);

    // BODY while idle is consumed and flagged; HEADTAIL then forwarded.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h07, 0);
    step(0, 1, 8'hC1, 0);
    step(0, 0, 8'h00, 0);

    // Credit overflow at full credit.
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    // Reset mid-packet, then a BODY is a framing error.
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h47, 0);
    step(1, 1, 8'h08, 0);
    step(0, 1, 8'h09, 0);
    step(0, 1, 8'h48, 0);
    step(0, 1, 8'hC2, 0);

    // Randomized traffic with mostly well-behaved credit returns.
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 600; i++) begin
      bit            r, v, c;
      logic [DW-1:0] f;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 9) < 7);
      f = DW'($urandom);
      if (m_cr < CMAX) c = ($urandom_range(0, 1) == 1);
      else             c = ($urandom_range(0, 24) == 0);
      step(r, v, f, c);
    end

    // Drain and make sure nothing expected is left outstanding.
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    chk("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
